// File: rtl/e203_ifu_bhtbpu.sv
// IFU dynamic branch predictor: 2-bit counter BHT with static fallback, JALR
// dependency handling and the one-shot regfile rs1 read. Optional RAS via E203_BPU_RAS_EN.
module e203_ifu_bhtbpu #(
    parameter int PC_W      = 32,
    parameter int BHT_IDX_W = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc,
    input  logic            dec_i_valid,
    input  logic            dec_i_fire,
    input  logic            dec_jal,
    input  logic            dec_jalr,
    input  logic            dec_bxx,
    input  logic            dec_rv32,
    input  logic [PC_W-1:0] dec_bjp_imm,
    input  logic [4:0]      dec_jalr_rs1idx,
    input  logic [4:0]      dec_rdidx,
    input  logic            oitf_empty,
    input  logic            ir_empty,
    input  logic            ir_rs1en,
    input  logic            ir_valid_clr,
    input  logic            jalr_rs1idx_cam_irrdidx,
    input  logic [PC_W-1:0] rf2bpu_x1,
    input  logic [PC_W-1:0] rf2bpu_rs1,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    output logic            bpu_wait,
    output logic            prdt_taken,
    output logic [PC_W-1:0] prdt_pc_add_op1,
    output logic [PC_W-1:0] prdt_pc_add_op2,
    output logic            bpu2rf_rs1_ena
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    typedef enum logic {
        RDRF_IDLE,
        RDRF_READ
    } rdrf_state_e;

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [BHT_N-1:0]     bht_vld;
    logic [1:0]           bht_ctr [BHT_N];
    logic [BHT_IDX_W-1:0] lkp_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [1:0]           upd_ctr_nxt;
    logic                 bxx_taken;

    assign lkp_idx = pc[BHT_IDX_W+1:2];
    assign upd_idx = upd_pc[BHT_IDX_W+1:2];

    // Untrained entries fall back to backward-taken / forward-not-taken.
    assign bxx_taken = bht_vld[lkp_idx] ? bht_ctr[lkp_idx][1] : dec_bjp_imm[PC_W-1];

    always_comb begin
        upd_ctr_nxt = bht_ctr[upd_idx];
        if (!bht_vld[upd_idx]) begin
            upd_ctr_nxt = upd_taken ? 2'b10 : 2'b01;
        end else if (upd_taken) begin
            if (bht_ctr[upd_idx] != 2'b11) upd_ctr_nxt = bht_ctr[upd_idx] + 2'b01;
        end else begin
            if (bht_ctr[upd_idx] != 2'b00) upd_ctr_nxt = bht_ctr[upd_idx] - 2'b01;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bht_vld <= '0;
            for (int i = 0; i < BHT_N; i++) bht_ctr[i] <= 2'b01;
        end else if (upd_valid) begin
            bht_vld[upd_idx] <= 1'b1;
            bht_ctr[upd_idx] <= upd_ctr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // JALR source classification
    // ------------------------------------------------------------------
    logic rs1x0;
    logic rs1x1;
    logic rs1xn;
    logic ras_hit;
    logic [PC_W-1:0] ras_top;

    assign rs1x0 = (dec_jalr_rs1idx == 5'd0);
    assign rs1x1 = (dec_jalr_rs1idx == 5'd1);
    assign rs1xn = ~rs1x0 & ~rs1x1;

`ifdef E203_BPU_RAS_EN
    // ------------------------------------------------------------------
    // Return-address stack: circular buffer, ras_ptr is the next write slot
    // ------------------------------------------------------------------
    localparam int RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]      ras_mem [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_ptr;
    logic [RAS_PTR_W-1:0] ras_top_idx;
    logic [RAS_CNT_W-1:0] ras_cnt;
    logic                 rd_link;
    logic                 rs1_link;
    logic                 ras_push;
    logic                 ras_pop;
    logic [PC_W-1:0]      ras_push_val;

    assign rd_link      = (dec_rdidx == 5'd1) | (dec_rdidx == 5'd5);
    assign rs1_link     = (dec_jalr_rs1idx == 5'd1) | (dec_jalr_rs1idx == 5'd5);
    assign ras_top_idx  = ras_ptr - 1'b1;
    assign ras_top      = ras_mem[ras_top_idx];
    assign ras_hit      = dec_i_valid & dec_jalr & rs1_link & (ras_cnt != '0);
    assign ras_pop      = dec_i_fire & ras_hit;
    assign ras_push     = dec_i_valid & dec_i_fire & (dec_jal | dec_jalr) & rd_link;
    assign ras_push_val = pc + (dec_rv32 ? PC_W'(4) : PC_W'(2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else begin
            case ({ras_pop, ras_push})
                2'b10: begin
                    ras_ptr <= ras_top_idx;
                    ras_cnt <= ras_cnt - 1'b1;
                end
                2'b01: begin
                    ras_ptr <= ras_ptr + 1'b1;
                    if (ras_cnt != RAS_CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
                end
                default: ;  // pop+push replaces the top in place
            endcase
        end
    end

    // NOTE: storage arrays are not reset; ras_cnt guards every read, so reset only costs area.
    always_ff @(posedge clk) begin
        if (ras_push) begin
            if (ras_pop) ras_mem[ras_top_idx] <= ras_push_val;
            else         ras_mem[ras_ptr]     <= ras_push_val;
        end
    end
`else
    logic unused_ras_inputs;

    assign ras_hit           = 1'b0;
    assign ras_top           = '0;
    assign unused_ras_inputs = ^{dec_i_fire, dec_rv32, dec_rdidx, RAS_DEPTH[0]};
`endif

    // ------------------------------------------------------------------
    // JALR dependency detection and one-shot rs1 read
    // ------------------------------------------------------------------
    logic        x1_dep;
    logic        xn_dep;
    logic        xn_dep_ir_clr;
    logic        rdrf_set;
    rdrf_state_e rdrf_state;
    rdrf_state_e rdrf_state_nxt;

    assign x1_dep = dec_i_valid & dec_jalr & rs1x1 & ~ras_hit
                  & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
    assign xn_dep = dec_i_valid & dec_jalr & rs1xn & ~ras_hit
                  & (~oitf_empty | ~ir_empty);
    // The IR producer is leaving or does not read rs1, so the read may start now.
    assign xn_dep_ir_clr = xn_dep & oitf_empty & ~ir_empty & (ir_valid_clr | ~ir_rs1en);

    always_ff @(posedge clk) begin
        if (!rst_n) rdrf_state <= RDRF_IDLE;
        else        rdrf_state <= rdrf_state_nxt;
    end

    always_comb begin
        rdrf_state_nxt = rdrf_state;
        rdrf_set       = 1'b0;
        case (rdrf_state)
            RDRF_IDLE: begin
                if (dec_i_valid & dec_jalr & rs1xn & ~ras_hit & (~xn_dep | xn_dep_ir_clr)) begin
                    rdrf_set       = 1'b1;
                    rdrf_state_nxt = RDRF_READ;
                end
            end
            RDRF_READ: rdrf_state_nxt = RDRF_IDLE;
            default:   rdrf_state_nxt = RDRF_IDLE;
        endcase
    end

    assign bpu2rf_rs1_ena = rdrf_set;
    assign bpu_wait       = x1_dep | xn_dep | rdrf_set;

    // ------------------------------------------------------------------
    // Prediction and next-PC adder operands
    // ------------------------------------------------------------------
    assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & bxx_taken);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        prdt_pc_add_op1 = rf2bpu_rs1;
        if (dec_bxx | dec_jal) prdt_pc_add_op1 = pc;
        else if (rs1x0)        prdt_pc_add_op1 = '0;
        else if (ras_hit)      prdt_pc_add_op1 = ras_top;
        else if (rs1x1)        prdt_pc_add_op1 = rf2bpu_x1;
    end

    assign prdt_pc_add_op2 = dec_bjp_imm;

    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc[PC_W-1:BHT_IDX_W+2], upd_pc[1:0]};

endmodule

// File: tb/tb_e203_ifu_bhtbpu.sv
// Directed self-checking bench for e203_ifu_bhtbpu; RAS steps run when E203_BPU_RAS_EN is defined.
module tb_e203_ifu_bhtbpu;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [PC_W-1:0] pc;
    logic            dec_i_valid, dec_i_fire, dec_jal, dec_jalr, dec_bxx, dec_rv32;
    logic [PC_W-1:0] dec_bjp_imm;
    logic [4:0]      dec_jalr_rs1idx, dec_rdidx;
    logic            oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx;
    logic [PC_W-1:0] rf2bpu_x1, rf2bpu_rs1;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic            bpu_wait, prdt_taken, bpu2rf_rs1_ena;
    logic [PC_W-1:0] prdt_pc_add_op1, prdt_pc_add_op2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e203_ifu_bhtbpu #(.PC_W(PC_W), .BHT_IDX_W(6), .RAS_DEPTH(4)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .pc                      (pc),
        .dec_i_valid             (dec_i_valid),
        .dec_i_fire              (dec_i_fire),
        .dec_jal                 (dec_jal),
        .dec_jalr                (dec_jalr),
        .dec_bxx                 (dec_bxx),
        .dec_rv32                (dec_rv32),
        .dec_bjp_imm             (dec_bjp_imm),
        .dec_jalr_rs1idx         (dec_jalr_rs1idx),
        .dec_rdidx               (dec_rdidx),
        .oitf_empty              (oitf_empty),
        .ir_empty                (ir_empty),
        .ir_rs1en                (ir_rs1en),
        .ir_valid_clr            (ir_valid_clr),
        .jalr_rs1idx_cam_irrdidx (jalr_rs1idx_cam_irrdidx),
        .rf2bpu_x1               (rf2bpu_x1),
        .rf2bpu_rs1              (rf2bpu_rs1),
        .upd_valid               (upd_valid),
        .upd_pc                  (upd_pc),
        .upd_taken               (upd_taken),
        .bpu_wait                (bpu_wait),
        .prdt_taken              (prdt_taken),
        .prdt_pc_add_op1         (prdt_pc_add_op1),
        .prdt_pc_add_op2         (prdt_pc_add_op2),
        .bpu2rf_rs1_ena          (bpu2rf_rs1_ena)
    );

    task automatic check(input string tag, input logic [PC_W-1:0] obs, input logic [PC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd_once(input logic [PC_W-1:0] addr, input logic taken);
        upd_pc    = addr;
        upd_taken = taken;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        pc = '0; dec_i_valid = 0; dec_i_fire = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
        dec_rv32 = 1; dec_bjp_imm = '0; dec_jalr_rs1idx = '0; dec_rdidx = '0;
        oitf_empty = 1; ir_empty = 1; ir_rs1en = 1; ir_valid_clr = 0; jalr_rs1idx_cam_irrdidx = 0;
        rf2bpu_x1 = 32'h0000_5550; rf2bpu_rs1 = 32'h0000_ABC0;
        upd_valid = 0; upd_pc = '0; upd_taken = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("reset_wait", bpu_wait, 0);
        check("reset_ena", bpu2rf_rs1_ena, 0);
        check("reset_prdt", prdt_taken, 0);

        // Static fallback on an untrained entry
        dec_i_valid = 1; dec_bxx = 1; pc = 32'h100; dec_bjp_imm = 32'hFFFF_FFF8;
        #1;
        check("static_back", prdt_taken, 1);
        check("bxx_op1", prdt_pc_add_op1, 32'h100);
        check("bxx_op2", prdt_pc_add_op2, 32'hFFFF_FFF8);
        dec_bjp_imm = 32'h8;
        #1;
        check("static_fwd", prdt_taken, 0);

        // Train pc 0x104: invalid->10->11
        pc = 32'h104; dec_bjp_imm = 32'h10;
        upd_once(32'h104, 1'b1);
        upd_once(32'h104, 1'b1);
        check("trained_11", prdt_taken, 1);
        upd_once(32'h104, 1'b0);
        check("ctr_10", prdt_taken, 1);
        upd_once(32'h104, 1'b0);
        check("ctr_01", prdt_taken, 0);
        upd_once(32'h104, 1'b0);
        check("ctr_00", prdt_taken, 0);
        upd_once(32'h104, 1'b0);
        check("ctr_00_sat", prdt_taken, 0);
        upd_once(32'h104, 1'b1);
        check("ctr_01_after_sat", prdt_taken, 0);
        upd_once(32'h104, 1'b1);
        check("ctr_10_again", prdt_taken, 1);

        // Same-cycle update and lookup: no bypass
        pc = 32'h108; dec_bjp_imm = 32'h8;
        upd_pc = 32'h108; upd_taken = 1; upd_valid = 1;
        #1;
        check("same_cycle_old", prdt_taken, 0);
        tick();
        upd_valid = 0;
        #1;
        check("next_cycle_new", prdt_taken, 1);

        // JAL and JALR x0
        dec_bxx = 0; dec_jal = 1; pc = 32'h180; dec_bjp_imm = 32'h40;
        #1;
        check("jal_prdt", prdt_taken, 1);
        check("jal_op1", prdt_pc_add_op1, 32'h180);
        check("jal_wait", bpu_wait, 0);
        dec_jal = 0; dec_jalr = 1; dec_jalr_rs1idx = 5'd0;
        #1;
        check("jalr_x0_op1", prdt_pc_add_op1, 32'h0);
        check("jalr_x0_wait", bpu_wait, 0);

        // JALR x1 dependency
        dec_jalr_rs1idx = 5'd1;
        #1;
        check("jalr_x1_nodep_wait", bpu_wait, 0);
        check("jalr_x1_op1", prdt_pc_add_op1, 32'h5550);
        jalr_rs1idx_cam_irrdidx = 1;
        #1;
        check("jalr_x1_cam_wait", bpu_wait, 1);
        jalr_rs1idx_cam_irrdidx = 0; oitf_empty = 0;
        #1;
        check("jalr_x1_oitf_wait", bpu_wait, 1);
        oitf_empty = 1;

        // JALR x7 one-shot regfile read
        dec_jalr_rs1idx = 5'd7;
        #1;
        check("rdrf_ena", bpu2rf_rs1_ena, 1);
        check("rdrf_wait", bpu_wait, 1);
        tick();
        check("read_ena", bpu2rf_rs1_ena, 0);
        check("read_wait", bpu_wait, 0);
        check("read_op1", prdt_pc_add_op1, 32'hABC0);
        dec_i_valid = 0;
        tick();

        // xN dependency on a busy IR, then released by ir_valid_clr
        dec_i_valid = 1; ir_empty = 0;
        #1;
        check("xn_dep_ena", bpu2rf_rs1_ena, 0);
        check("xn_dep_wait", bpu_wait, 1);
        ir_valid_clr = 1;
        #1;
        check("xn_clr_ena", bpu2rf_rs1_ena, 1);
        check("xn_clr_wait", bpu_wait, 1);
        tick();
        check("xn_read_ena", bpu2rf_rs1_ena, 0);

        // Reset from READ, with an update that must be ignored
        rst_n = 0; upd_pc = 32'h10C; upd_taken = 1; upd_valid = 1;
        tick();
        rst_n = 1; upd_valid = 0; ir_empty = 1; ir_valid_clr = 0;
        #1;
        check("post_rst_rdrf_ena", bpu2rf_rs1_ena, 1);
        dec_jalr = 0; dec_bxx = 1; pc = 32'h10C; dec_bjp_imm = 32'h8;
        #1;
        check("rst_upd_ignored", prdt_taken, 0);
        pc = 32'h104; dec_bjp_imm = 32'h10;
        #1;
        check("rst_clears_bht", prdt_taken, 0);
        dec_bxx = 0; dec_i_valid = 0;
        tick();

`ifdef E203_BPU_RAS_EN
        // Call at 0x200, return with the OITF busy uses the RAS
        dec_i_valid = 1; dec_i_fire = 1; dec_jal = 1; dec_rdidx = 5'd1; dec_rv32 = 1; pc = 32'h200;
        tick();
        dec_i_fire = 0; dec_jal = 0; dec_jalr = 1; dec_jalr_rs1idx = 5'd1; dec_rdidx = 5'd0;
        oitf_empty = 0; pc = 32'h400;
        #1;
        check("ras_ret_wait", bpu_wait, 0);
        check("ras_ret_op1", prdt_pc_add_op1, 32'h204);
        dec_i_fire = 1;
        tick();
        dec_i_fire = 0;
        #1;
        check("ras_empty_wait", bpu_wait, 1);
        check("ras_empty_op1", prdt_pc_add_op1, 32'h5550);

        // Five calls overflow a depth-4 RAS; four returns hit, the fifth falls back
        dec_jalr = 0; dec_jal = 1; dec_rdidx = 5'd1;
        for (int i = 0; i < 5; i++) begin
            pc = 32'h1000 + 32'(i * 16);
            dec_i_fire = 1;
            tick();
        end
        dec_jal = 0; dec_jalr = 1; dec_jalr_rs1idx = 5'd1; dec_rdidx = 5'd0; pc = 32'h400;
        for (int i = 0; i < 4; i++) begin
            dec_i_fire = 0;
            #1;
            check("ras_pop_op1", prdt_pc_add_op1, 32'h1044 - 32'(i * 16));
            check("ras_pop_wait", bpu_wait, 0);
            dec_i_fire = 1;
            tick();
        end
        dec_i_fire = 0;
        #1;
        check("ras_fifth_wait", bpu_wait, 1);
        check("ras_fifth_op1", prdt_pc_add_op1, 32'h5550);

        // 16-bit call through x5, return through x5 skips the regfile read
        oitf_empty = 1; dec_jalr = 0; dec_jal = 1; dec_rdidx = 5'd5; dec_rv32 = 0; pc = 32'h300;
        dec_i_fire = 1;
        tick();
        dec_i_fire = 0; dec_jal = 0; dec_jalr = 1; dec_jalr_rs1idx = 5'd5; dec_rdidx = 5'd0;
        #1;
        check("ras_x5_op1", prdt_pc_add_op1, 32'h302);
        check("ras_x5_ena", bpu2rf_rs1_ena, 0);
        check("ras_x5_wait", bpu_wait, 0);
`else
        // Without the RAS a return after a call still waits on x1
        dec_i_valid = 1; dec_i_fire = 1; dec_jal = 1; dec_rdidx = 5'd1; pc = 32'h200;
        tick();
        dec_i_fire = 0; dec_jal = 0; dec_jalr = 1; dec_jalr_rs1idx = 5'd1; dec_rdidx = 5'd0;
        oitf_empty = 0;
        #1;
        check("ret_x1_wait", bpu_wait, 1);
        check("ret_x1_op1", prdt_pc_add_op1, 32'h5550);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
